// File: rtl/mul_retire_q_pkg.sv
// Shared types and widths for the multiplier completion queue.
// The LG_* widths and MUL_LAT mirror the values of the shared uop definitions so that
// this block's tag fields line up with the rest of the core.
package mul_retire_q_pkg;

    localparam int unsigned LG_ROB_ENTRIES      = 6;
    localparam int unsigned LG_PRF_ENTRIES      = 7;
    localparam int unsigned LG_HILO_PRF_ENTRIES = 2;
    localparam int unsigned MUL_LAT             = 3;

    // One completed multiply: destination tags plus the accumulated 64-bit result.
    typedef struct packed {
        logic [LG_ROB_ENTRIES-1:0]      rob_ptr;
        logic                           gpr_val;
        logic [LG_PRF_ENTRIES-1:0]      gpr_ptr;
        logic                           hilo_val;
        logic [LG_HILO_PRF_ENTRIES-1:0] hilo_ptr;
        logic [63:0]                    r;
    } mul_retire_entry_t;

    // MADD/MSUB accumulate; modulo 2^64 so signedness does not matter.
    function automatic logic [63:0] mul_accumulate(
        input logic        do_madd,
        input logic        do_msub,
        input logic [63:0] y,
        input logic [63:0] src
    );
        logic [63:0] r;
        if (do_madd) begin
            r = src + y;
        end else if (do_msub) begin
            r = src - y;
        end else begin
            r = y;
        end
        return r;
    endfunction

endpackage

// File: rtl/mul_retire_fifo.sv
// Circular FIFO holding completed multiply entries.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   clear          flush: empties the FIFO next cycle
//   push, wdata    write request; accepted when not full, or when full with a pop
//   pop            read request; ignored when empty
//   rdata          head entry (valid when !empty)
//   empty, full    occupancy flags
//   count          number of stored entries (0..DEPTH)
module mul_retire_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    head_q, head_d;
    logic [AW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign rdata = mem_q[head_q];

    // A push into a full FIFO only succeeds if the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) begin
                mem_d[tail_q] = wdata;
                tail_d        = tail_q + AW'(1);
            end
            if (do_pop) begin
                head_d = head_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: only entries below count are ever observed.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/mul_retire_q.sv
// Completion queue behind the pipelined integer multiplier.
// Registers each product with its tags (applying MADD/MSUB against the HI/LO source),
// buffers results in a FIFO until the writeback arbiter takes them, and raises
// mul_busy early enough that the non-stallable multiplier can never overrun it.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   clear                       flush staged and buffered entries (overflow kept)
//   mul_*                       multiplier result, tags and accumulate controls
//   mul_busy                    issue must not send a new multiply
//   out_valid/out_ready         head handshake to the arbiter
//   out_*                       head tags and data; val bits and data are 0 when !out_valid
//   overflow                    sticky: a result was dropped because the FIFO was full
module mul_retire_q
    import mul_retire_q_pkg::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned IN_FLIGHT = MUL_LAT + 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clear,
    input  logic                           mul_complete,
    input  logic [63:0]                    mul_y,
    input  logic [LG_ROB_ENTRIES-1:0]      mul_rob_ptr,
    input  logic                           mul_gpr_val,
    input  logic [LG_PRF_ENTRIES-1:0]      mul_gpr_ptr,
    input  logic                           mul_hilo_val,
    input  logic [LG_HILO_PRF_ENTRIES-1:0] mul_hilo_ptr,
    input  logic                           mul_do_madd,
    input  logic                           mul_do_msub,
    input  logic [63:0]                    mul_hilo_src,
    output logic                           mul_busy,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [LG_ROB_ENTRIES-1:0]      out_rob_ptr,
    output logic                           out_gpr_val,
    output logic [LG_PRF_ENTRIES-1:0]      out_gpr_ptr,
    output logic                           out_hilo_val,
    output logic [LG_HILO_PRF_ENTRIES-1:0] out_hilo_ptr,
    output logic [63:0]                    out_gpr_data,
    output logic [63:0]                    out_hilo_data,
    output logic                           overflow
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned EW = $bits(mul_retire_entry_t);

    logic              s1_valid_q, s1_valid_d;
    mul_retire_entry_t s1_entry_q, s1_entry_d;
    logic              overflow_q, overflow_d;

    logic [EW-1:0]     fifo_rdata;
    logic              fifo_empty;
    logic              fifo_full;
    logic [CW-1:0]     fifo_count;
    logic              fifo_pop;
    mul_retire_entry_t head;
    logic [31:0]       occupancy;

    // Accumulate stage; a completion in a clear cycle is discarded.
    always_comb begin
        s1_valid_d = mul_complete && !clear;
        s1_entry_d = s1_entry_q;
        if (mul_complete) begin
            s1_entry_d.rob_ptr  = mul_rob_ptr;
            s1_entry_d.gpr_val  = mul_gpr_val;
            s1_entry_d.gpr_ptr  = mul_gpr_ptr;
            s1_entry_d.hilo_val = mul_hilo_val;
            s1_entry_d.hilo_ptr = mul_hilo_ptr;
            s1_entry_d.r        = mul_accumulate(mul_do_madd, mul_do_msub, mul_y, mul_hilo_src);
        end
    end

    // A drop is a push into a full FIFO that no pop makes room for; a flushed push is not.
    always_comb begin
        overflow_d = overflow_q;
        if (s1_valid_q && fifo_full && !fifo_pop && !clear) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_entry_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_entry_q <= s1_entry_d;
            overflow_q <= overflow_d;
        end
    end

    mul_retire_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .push  (s1_valid_q),
        .wdata (s1_entry_q),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign out_valid = !fifo_empty;
    assign fifo_pop  = out_valid && out_ready;
    assign head      = mul_retire_entry_t'(fifo_rdata);

    // Registers only: the staged entry counts because it will land in the FIFO next cycle.
    assign occupancy = 32'(fifo_count) + 32'(s1_valid_q);
    assign mul_busy  = occupancy >= 32'(DEPTH - IN_FLIGHT);
    assign overflow  = overflow_q;

    always_comb begin
        out_rob_ptr   = '0;
        out_gpr_val   = 1'b0;
        out_gpr_ptr   = '0;
        out_hilo_val  = 1'b0;
        out_hilo_ptr  = '0;
        out_gpr_data  = '0;
        out_hilo_data = '0;
        if (out_valid) begin
            out_rob_ptr   = head.rob_ptr;
            out_gpr_val   = head.gpr_val;
            out_gpr_ptr   = head.gpr_ptr;
            out_hilo_val  = head.hilo_val;
            out_hilo_ptr  = head.hilo_ptr;
            out_gpr_data  = {{32{head.r[31]}}, head.r[31:0]};
            out_hilo_data = head.r;
        end
    end

endmodule

// File: doc/mul_retire_q.md
# mul_retire_q

Completion queue directly downstream of the pipelined integer multiplier. It captures each multiplier result and its tags, and applies the MADD/MSUB accumulate against the HI/LO source value in a single registered stage. It then buffers completed results in a FIFO until the writeback/completion arbiter accepts them. It also gives issue logic a credit signal, so the non-stallable multiplier pipeline can never overrun the queue.

## Interface
Parameters:
- DEPTH, 8, FIFO entries (power of two, ≥ 4)
- IN_FLIGHT, `MUL_LAT+1`, maximum multiplier ops that can be in flight after issue is blocked

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- clear  in  1  pipeline flush; discards all buffered and staged entries
- mul_complete  in  1  multiplier result valid this cycle
- mul_y  in  64  raw product
- mul_rob_ptr  in  `LG_ROB_ENTRIES`  ROB tag
- mul_gpr_val / mul_gpr_ptr  in  1 / `LG_PRF_ENTRIES`  GPR destination
- mul_hilo_val / mul_hilo_ptr  in  1 / `LG_HILO_PRF_ENTRIES`  HI/LO destination
- mul_do_madd, mul_do_msub  in  1 each  accumulate mode (mutually exclusive)
- mul_hilo_src  in  64  HI/LO source value for the accumulate
- mul_busy  out  1  issue must not send a new multiply
- out_valid  out  1  head entry valid
- out_ready  in  1  arbiter accepts head
- out_rob_ptr, out_gpr_val, out_gpr_ptr, out_hilo_val, out_hilo_ptr  out  as inputs  head tags
- out_gpr_data  out  64  {{32{r[31]}}, r[31:0]}
- out_hilo_data  out  64  full 64-bit result r
- overflow  out  1  sticky error: push dropped while full

## Operation
- Stage S1 (registered), loaded when mul_complete=1:
  - r = mul_hilo_src + mul_y if do_madd.
  - r = mul_hilo_src − mul_y if do_msub.
  - r = mul_y otherwise.
  - Arithmetic is modulo 2^64, so signedness is irrelevant.
  - Tags are registered alongside r.
- FIFO push occurs when S1 is valid. FIFO pop occurs when out_valid && out_ready.
- Head, tail and count are held in registers. Pointers wrap modulo DEPTH.
- out_* is driven from the head entry. When out_valid=0, out_* fields are don't-care, but the val bits are forced to 0.
- Push and pop in the same cycle while full: both happen and count is unchanged. No overflow is flagged.
- Push while full with no pop: the entry is dropped and overflow is set to 1. overflow stays set until reset.
- Push and pop in the same cycle while empty: not possible, because the head is not valid in that cycle.
- mul_busy = (count + S1_valid) ≥ DEPTH − IN_FLIGHT. It is combinational from registers only, with no input-to-output path.
- clear:
  - Next cycle: count=0, S1_valid=0, pointers = 0.
  - An mul_complete arriving in the same cycle as clear is discarded.
  - overflow is unaffected.
- reset: same effect as clear, and in addition overflow=0. Reset takes priority over everything.

## Timing
- Reset values: out_valid=0, mul_busy=0, overflow=0, all out_* val bits=0, data outputs 0.
- Latency:
  - mul_complete at cycle T → entry in S1 at T+1.
  - Entry in FIFO and out_valid=1 at T+2 if the FIFO was empty.
- Throughput: one push and one pop per cycle sustained.
- Handshake:
  - out_valid never deasserts without a pop, clear or reset.
  - Head contents are stable while out_valid && !out_ready.
- mul_busy reflects state in the same cycle. Issue samples it before asserting go.
- Results leave the queue in arrival order; ordering is preserved.

## Structure
- The `LG_*` widths and `MUL_LAT` come from the shared uop.vh defines. Nothing new is added there.
- Entry struct typedef mul_retire_entry_t (tags + 64-bit r) is local to this block.
- One sub-module: `mul_retire_fifo` (parameterized DEPTH, payload width), holding the storage array, pointers, count, and full/empty logic. The accumulate stage and busy/overflow logic live in the top.

## Test plan
- Plain MUL with out_ready=1: mul_y=0x0000_0001_8000_0000, gpr_val=1, ptr=5 at T → out_valid at T+2, out_gpr_data=0xFFFF_FFFF_8000_0000, out_gpr_ptr=5.
- MADD/MSUB:
  - MADD with hilo_src=0xFFFF_FFFF_FFFF_FFFF, mul_y=1 → out_hilo_data=0.
  - MSUB with hilo_src=0, mul_y=1 → out_hilo_data=0xFFFF_FFFF_FFFF_FFFF.
- Backpressure with out_ready=0 and DEPTH=8, IN_FLIGHT=4:
  - After 4 pushes, mul_busy=1.
  - Forcing 9 pushes → overflow=1, and the 8 stored entries drain in order with their rob_ptrs.
- Full with simultaneous push and pop, out_ready=1: count stays 8, overflow stays 0, order preserved.
- clear while 3 entries are queued and mul_complete=1 in the same cycle → next cycle out_valid=0 and mul_busy=0. The following push appears at T+2.
- reset mid-stream with overflow set → all outputs at reset values the next cycle, overflow=0.
